cvs_channel_scheduler: RTL and testbench

//  Sequences the five channel inputs of simple_fpga_cvs. Steps through a

---
 rtl/cvs_channel_scheduler.sv | 168 ++++++++++++++++
 tb/tb_cvs_channel_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cvs_channel_scheduler.sv
// ============================================================================
// cvs_channel_scheduler
// Steps a one-hot enable through the masked CVS channels with a dwell period
// per channel and an optional idle gap between them; one-shot or looping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cvs_channel_scheduler #(
  parameter int NUM_CHANNELS = 5,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            loop,
  input  logic [NUM_CHANNELS-1:0]         channel_mask,
  input  logic [COUNT_WIDTH-1:0]          dwell_cycles,
  input  logic [COUNT_WIDTH-1:0]          gap_cycles,
  output logic [NUM_CHANNELS-1:0]         channel_enable,
  output logic [$clog2(NUM_CHANNELS)-1:0] active_channel,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  localparam int c_IDX_W = $clog2(NUM_CHANNELS);
  localparam logic [COUNT_WIDTH-1:0] c_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t                  r_state;
  logic [NUM_CHANNELS-1:0] r_mask;
  logic [COUNT_WIDTH-1:0]  r_dwell;
  logic [COUNT_WIDTH-1:0]  r_gap;
  logic                    r_loop;
  logic [COUNT_WIDTH-1:0]  r_cnt;

  logic [c_IDX_W-1:0]      w_first_idx;
  logic [c_IDX_W-1:0]      w_low_idx;
  logic [c_IDX_W-1:0]      w_above_idx;
  logic                    w_above_found;
  logic [c_IDX_W-1:0]      w_next_idx;
  logic [COUNT_WIDTH-1:0]  w_dwell_in;
  logic                    w_cnt_expired;
  logic [NUM_CHANNELS-1:0] w_first_onehot;
  logic [NUM_CHANNELS-1:0] w_next_onehot;

  // Descending scans: the last hit assigned is the lowest qualifying index.
  always_comb begin
    w_first_idx   = '0;
    w_low_idx     = '0;
    w_above_idx   = '0;
    w_above_found = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (channel_mask[i]) begin
        w_first_idx = c_IDX_W'(i);
      end
      if (r_mask[i]) begin
        w_low_idx = c_IDX_W'(i);
        if (i > int'(active_channel)) begin
          w_above_idx   = c_IDX_W'(i);
          w_above_found = 1'b1;
        end
      end
    end
  end

  assign w_next_idx    = w_above_found ? w_above_idx : w_low_idx;
  assign w_dwell_in    = (dwell_cycles == '0) ? c_ONE : dwell_cycles;
  assign w_cnt_expired = (r_cnt <= c_ONE);

  generate
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_onehot
      assign w_first_onehot[g] = (w_first_idx == c_IDX_W'(g));
      assign w_next_onehot[g]  = (w_next_idx == c_IDX_W'(g));
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_mask         <= '0;
      r_dwell        <= '0;
      r_gap          <= '0;
      r_loop         <= 1'b0;
      r_cnt          <= '0;
      channel_enable <= '0;
      active_channel <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (stop) begin
        r_state        <= S_IDLE;
        channel_enable <= '0;
        busy           <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (channel_mask == '0) begin
                error <= 1'b1;
              end else begin
                r_mask         <= channel_mask;
                r_dwell        <= w_dwell_in;
                r_gap          <= gap_cycles;
                r_loop         <= loop;
                r_cnt          <= w_dwell_in;
                channel_enable <= w_first_onehot;
                active_channel <= w_first_idx;
                busy           <= 1'b1;
                r_state        <= S_DWELL;
              end
            end
          end

          S_DWELL: begin
            if (!w_cnt_expired) begin
              r_cnt <= r_cnt - c_ONE;
            end else if (!w_above_found && !r_loop) begin
              // One-shot run finished: no trailing gap after the last channel.
              r_state        <= S_IDLE;
              channel_enable <= '0;
              busy           <= 1'b0;
              done           <= 1'b1;
            end else if (r_gap != '0) begin
              r_state        <= S_GAP;
              channel_enable <= '0;
              r_cnt          <= r_gap;
            end else begin
              channel_enable <= w_next_onehot;
              active_channel <= w_next_idx;
              r_cnt          <= r_dwell;
            end
          end

          S_GAP: begin
            if (!w_cnt_expired) begin
              r_cnt <= r_cnt - c_ONE;
            end else begin
              r_state        <= S_DWELL;
              channel_enable <= w_next_onehot;
              active_channel <= w_next_idx;
              r_cnt          <= r_dwell;
            end
          end

          default: begin
            r_state        <= S_IDLE;
            channel_enable <= '0;
            busy           <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cvs_channel_scheduler.sv
// ============================================================================
// tb_cvs_channel_scheduler
// Directed per-cycle vector table plus hand sequences for reset and looping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cvs_channel_scheduler;

  localparam int NUM_CHANNELS = 5;
  localparam int COUNT_WIDTH  = 16;
  localparam int IDX_W        = 3;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic                    start;
  logic                    stop;
  logic                    loop;
  logic [NUM_CHANNELS-1:0] channel_mask;
  logic [COUNT_WIDTH-1:0]  dwell_cycles;
  logic [COUNT_WIDTH-1:0]  gap_cycles;
  logic [NUM_CHANNELS-1:0] channel_enable;
  logic [IDX_W-1:0]        active_channel;
  logic                    busy;
  logic                    done;
  logic                    error;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic                    start;
    logic                    stop;
    logic                    loop;
    logic [NUM_CHANNELS-1:0] mask;
    logic [COUNT_WIDTH-1:0]  dwell;
    logic [COUNT_WIDTH-1:0]  gap;
    logic [NUM_CHANNELS-1:0] en;
    logic [IDX_W-1:0]        act;
    logic                    busy;
    logic                    done;
    logic                    err;
  } vec_t;

  vec_t vecs[$];

  cvs_channel_scheduler #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .COUNT_WIDTH  (COUNT_WIDTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .loop           (loop),
    .channel_mask   (channel_mask),
    .dwell_cycles   (dwell_cycles),
    .gap_cycles     (gap_cycles),
    .channel_enable (channel_enable),
    .active_channel (active_channel),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clock = ~clock;

  task automatic add(input logic st, input logic sp, input logic lp,
                     input logic [NUM_CHANNELS-1:0] m,
                     input logic [COUNT_WIDTH-1:0] dw, input logic [COUNT_WIDTH-1:0] gp,
                     input logic [NUM_CHANNELS-1:0] en, input logic [IDX_W-1:0] act,
                     input logic b, input logic d, input logic e);
    vec_t v;
    v.start = st; v.stop = sp; v.loop = lp; v.mask = m; v.dwell = dw; v.gap = gp;
    v.en = en; v.act = act; v.busy = b; v.done = d; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [NUM_CHANNELS-1:0] en,
                       input logic [IDX_W-1:0] act, input logic b, input logic d,
                       input logic e);
    n_cmp++;
    if ({channel_enable, active_channel, busy, done, error} !== {en, act, b, d, e}) begin
      n_err++;
      $display("FAIL %s: got en=%b act=%0d busy=%b done=%b err=%b, want en=%b act=%0d busy=%b done=%b err=%b",
               name, channel_enable, active_channel, busy, done, error, en, act, b, d, e);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic lp,
                       input logic [NUM_CHANNELS-1:0] m,
                       input logic [COUNT_WIDTH-1:0] dw, input logic [COUNT_WIDTH-1:0] gp);
    start = st; stop = sp; loop = lp; channel_mask = m; dwell_cycles = dw; gap_cycles = gp;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 16'd0, 16'd0);

    // Idle / error / start+stop, then the 10101 one-shot run with config
    // inputs changed mid-run and start pulses while busy.
    add(0,0,0, 5'b00000, 16'd0, 16'd0,  5'b00000, 3'd0, 0,0,0);
    add(1,0,0, 5'b00000, 16'd3, 16'd2,  5'b00000, 3'd0, 0,0,1);
    add(0,0,0, 5'b00000, 16'd3, 16'd2,  5'b00000, 3'd0, 0,0,0);
    add(1,1,0, 5'b10101, 16'd3, 16'd2,  5'b00000, 3'd0, 0,0,0);
    add(1,0,0, 5'b10101, 16'd3, 16'd2,  5'b00001, 3'd0, 1,0,0); // E0
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b00001, 3'd0, 1,0,0); // E1
    add(1,0,1, 5'b11111, 16'd9, 16'd0,  5'b00001, 3'd0, 1,0,0); // E2
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b00000, 3'd0, 1,0,0); // E3
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b00000, 3'd0, 1,0,0); // E4
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b00100, 3'd2, 1,0,0); // E5
    add(1,0,1, 5'b11111, 16'd9, 16'd0,  5'b00100, 3'd2, 1,0,0); // E6
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b00100, 3'd2, 1,0,0); // E7
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b00000, 3'd2, 1,0,0); // E8
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b00000, 3'd2, 1,0,0); // E9
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b10000, 3'd4, 1,0,0); // E10
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b10000, 3'd4, 1,0,0); // E11
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b10000, 3'd4, 1,0,0); // E12
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b00000, 3'd4, 0,1,0); // E13
    add(0,0,1, 5'b11111, 16'd9, 16'd0,  5'b00000, 3'd4, 0,0,0); // E14
    // Single-channel loop: re-dwell with a one-cycle gap, then stop.
    add(1,0,1, 5'b01000, 16'd2, 16'd1,  5'b01000, 3'd3, 1,0,0);
    add(0,0,1, 5'b01000, 16'd2, 16'd1,  5'b01000, 3'd3, 1,0,0);
    add(0,0,1, 5'b01000, 16'd2, 16'd1,  5'b00000, 3'd3, 1,0,0);
    add(0,0,1, 5'b01000, 16'd2, 16'd1,  5'b01000, 3'd3, 1,0,0);
    add(0,0,1, 5'b01000, 16'd2, 16'd1,  5'b01000, 3'd3, 1,0,0);
    add(0,0,1, 5'b01000, 16'd2, 16'd1,  5'b00000, 3'd3, 1,0,0);
    add(0,0,1, 5'b01000, 16'd2, 16'd1,  5'b01000, 3'd3, 1,0,0);
    add(0,1,1, 5'b01000, 16'd2, 16'd1,  5'b00000, 3'd3, 0,0,0);
    add(0,0,1, 5'b01000, 16'd2, 16'd1,  5'b00000, 3'd3, 0,0,0);

    repeat (3) @(posedge clock);
    #1;
    check("reset_state", 5'b00000, 3'd0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i].start, vecs[i].stop, vecs[i].loop, vecs[i].mask, vecs[i].dwell, vecs[i].gap);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), vecs[i].en, vecs[i].act, vecs[i].busy, vecs[i].done, vecs[i].err);
    end

    // Two-channel loop with zero dwell and gap: enable toggles every cycle.
    @(negedge clock);
    drive(1'b1, 1'b0, 1'b1, 5'b00110, 16'd0, 16'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (k % 2 == 0) check($sformatf("loop2_%0d", k), 5'b00010, 3'd1, 1, 0, 0);
      else            check($sformatf("loop2_%0d", k), 5'b00100, 3'd2, 1, 0, 0);
      @(negedge clock);
      start = 1'b0;
    end
    stop = 1'b1;
    @(posedge clock);
    #1;
    check("loop2_stop", 5'b00000, 3'd2, 0, 0, 0);
    @(negedge clock);
    stop = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
      check("loop2_after_stop", 5'b00000, 3'd2, 0, 0, 0);
    end

    // Asynchronous reset in the middle of a dwell, then a clean restart.
    @(negedge clock);
    drive(1'b1, 1'b0, 1'b0, 5'b00100, 16'd5, 16'd0);
    @(posedge clock);
    #1;
    check("pre_reset_dwell", 5'b00100, 3'd2, 1, 0, 0);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 5'b00000, 3'd0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("post_reset_idle", 5'b00000, 3'd0, 0, 0, 0);
    @(negedge clock);
    drive(1'b1, 1'b0, 1'b0, 5'b00011, 16'd1, 16'd0);
    @(posedge clock);
    #1;
    check("restart_e0", 5'b00001, 3'd0, 1, 0, 0);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    check("restart_e1", 5'b00010, 3'd1, 1, 0, 0);
    @(posedge clock);
    #1;
    check("restart_done", 5'b00000, 3'd1, 0, 1, 0);
    @(posedge clock);
    #1;
    check("restart_idle", 5'b00000, 3'd1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
